// File: rtl/k_fifo_pkg.sv
// Shared sizing helpers for the k_fifo controller family.
// Depth and pointer width are both derived from the RAM address width.
package k_fifo_pkg;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // One extra MSB lets a pointer distinguish full from empty.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/k_fifo_ptr_t1.sv
// FIFO pointer: a free-running counter with one wrap bit above the RAM address.
// It advances by one on each enabled edge and is cleared by rst.
module k_fifo_ptr_t1
  import k_fifo_pkg::*;
#(
  parameter int addr_size = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [addr_size:0]   ptr
);

  localparam int PW = ptr_width(addr_size);

  logic [PW-1:0] ptr_p1;

  // The increment wraps modulo 2^PW through the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p1 <= '0;
    end else if (en) begin
      ptr_p1 <= ptr_p1 + 1'b1;
    end
  end

  assign ptr = ptr_p1;

endmodule

// File: rtl/k_fifo_ctrl_t1.sv
// Synchronous FIFO controller for a show-ahead dual-port RAM: addresses, write
// enable, occupancy count, registered full/empty/almost flags, sticky error flags.
module k_fifo_ctrl_t1
  import k_fifo_pkg::*;
#(
  parameter int addr_size = 1,
  parameter int af_level  = 1,
  parameter int ae_level  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic                   wen,
  output logic [addr_size-1:0]   waddr,
  output logic [addr_size-1:0]   raddr,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [addr_size:0]     count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CW    = ptr_width(addr_size);
  localparam int DEPTH = fifo_depth(addr_size);

  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW-1:0] count_p1;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] count_in;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;

  // Flag helpers evaluated on the occupancy that will be registered.
  function automatic logic is_full(input logic [CW-1:0] c);
    return 32'(c) == DEPTH;
  endfunction

  function automatic logic is_af(input logic [CW-1:0] c);
    return 32'(c) >= af_level;
  endfunction

  function automatic logic is_ae(input logic [CW-1:0] c);
    return 32'(c) <= ae_level;
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the head slot.
  always_comb begin
    do_push = push & (~full | pop);
    do_pop  = pop & ~empty;
    ovf_set = push & ~do_push;
    unf_set = pop & empty;
  end

  assign wen = do_push & ~rst;

  k_fifo_ptr_t1 #(.addr_size(addr_size)) u_wptr (
    .clk (clk),
    .rst (rst),
    .en  (do_push),
    .ptr (wptr)
  );

  k_fifo_ptr_t1 #(.addr_size(addr_size)) u_rptr (
    .clk (clk),
    .rst (rst),
    .en  (do_pop),
    .ptr (rptr)
  );

  assign waddr = wptr[addr_size-1:0];
  assign raddr = rptr[addr_size-1:0];

  always_comb begin
    count_nxt = count_p1;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_p1 + 1'b1;
      2'b01:   count_nxt = count_p1 - 1'b1;
      default: count_nxt = count_p1;
    endcase
    count_in = rst ? '0 : count_nxt;
  end

  // Routing reset through count_in gives the flags their reset values for free,
  // including almost_full when af_level is zero.
  always_ff @(posedge clk) begin
    count_p1     <= count_in;
    full         <= is_full(count_in);
    empty        <= (count_in == '0);
    almost_full  <= is_af(count_in);
    almost_empty <= is_ae(count_in);
  end

  // Error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  assign count = count_p1;

endmodule
